riscv_alu_issue: RTL and testbench

RISCV_ALU_ISSUE -- requirements
Module: riscv_alu_issue

---
 rtl/riscv_core_pkg.sv | 19 +
 rtl/riscv_alu_issue_if.sv | 26 ++
 rtl/riscv_alu_issue_watchdog.sv | 29 ++
 rtl/riscv_alu_issue.sv | 107 ++++++++++
 tb/tb_riscv_alu_issue.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared widths, FSM state encoding and RV32 ALU/M-extension opcode fields
package riscv_core_pkg;
    localparam int XLEN = 32;
    localparam int F7_M_BIT = 0;
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_DIV = 3'b100;
    function automatic logic is_m_op(input logic is_alu, input logic [6:0] funct7);
        return is_alu && funct7[F7_M_BIT];
    endfunction
endpackage

// File: rtl/riscv_alu_issue_if.sv
// riscv_alu_issue_if: decode, ALU and writeback signals of the ALU issue stage
interface riscv_alu_issue_if;
    logic in_valid, in_ready, in_is_op_alu, in_is_op_alu_imm;
    logic [2:0] in_funct3;
    logic [6:0] in_funct7;
    logic [4:0] in_rd;
    logic [riscv_core_pkg::XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
    logic is_op_alu, is_op_alu_imm;
    logic [2:0] op_funct3;
    logic [6:0] op_funct7;
    logic [riscv_core_pkg::XLEN-1:0] reg_s1, reg_s2, imm, rd_alu, wb_data;
    logic is_alu_wait, wb_valid, wb_ready, flush, busy_valid, illegal, wd_err;
    logic [4:0] wb_rd, busy_rd;
    modport slave (
        input  in_valid, in_is_op_alu, in_is_op_alu_imm, in_funct3, in_funct7, in_rd,
               in_rs1_val, in_rs2_val, in_imm, rd_alu, is_alu_wait, wb_ready, flush,
        output in_ready, is_op_alu, is_op_alu_imm, op_funct3, op_funct7, reg_s1, reg_s2, imm,
               wb_valid, wb_rd, wb_data, busy_valid, busy_rd, illegal, wd_err
    );
    modport master (
        output in_valid, in_is_op_alu, in_is_op_alu_imm, in_funct3, in_funct7, in_rd,
               in_rs1_val, in_rs2_val, in_imm, rd_alu, is_alu_wait, wb_ready, flush,
        input  in_ready, is_op_alu, is_op_alu_imm, op_funct3, op_funct7, reg_s1, reg_s2, imm,
               wb_valid, wb_rd, wb_data, busy_valid, busy_rd, illegal, wd_err
    );
endinterface

// File: rtl/riscv_alu_issue_watchdog.sv
// riscv_alu_issue_watchdog: counts EXEC cycles and raises a sticky error at WAIT_LIMIT
module riscv_alu_issue_watchdog #(
    parameter int WAIT_LIMIT = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic err_o
);
    logic [6:0] cnt_q, cnt_d;
    logic err_q, err_d;
    // count EXEC cycles (saturating), flag once the count reaches the limit
    always_comb begin
        cnt_d = clear_i ? '0 : (run_i && cnt_q != '1) ? cnt_q + 7'd1 : cnt_q;
        err_d = err_q || (run_i && cnt_d == 7'(WAIT_LIMIT));
    end
    // counter and sticky error state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: single-slot issue stage feeding an external ALU; define RISCV_M_EXT_EN to issue multiply/divide
module riscv_alu_issue
    import riscv_core_pkg::*;
#(
    parameter int WAIT_LIMIT = 64
) (
    input  logic clock,
    input  logic reset_n,
    riscv_alu_issue_if.slave bus
);
    state_e state_q, state_d;
    logic op_alu_q, op_alu_d, op_imm_q, op_imm_d, killed_q, killed_d, illegal_q, illegal_d;
    logic [2:0] funct3_q, funct3_d;
    logic [6:0] funct7_q, funct7_d;
    logic [4:0] rd_q, rd_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, wb_data_q, wb_data_d;
    logic accept, bad_op, issue, exec, hold, done, busy;
`ifdef RISCV_M_EXT_EN
    assign bad_op = 1'b0;
`else
    assign bad_op = is_m_op(bus.in_is_op_alu, bus.in_funct7);
`endif
    assign accept = bus.in_valid && bus.in_ready;
    assign issue = accept && !bad_op && !bus.flush;
    assign exec = state_q == EXEC;
    assign hold = state_q == HOLD;
    assign done = exec && !bus.is_alu_wait;
    // next state: a flushed or rd=0 result retires silently, otherwise wait in HOLD for writeback
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = issue ? EXEC : IDLE;
            EXEC: state_d = bus.is_alu_wait ? EXEC : (rd_q == '0 || killed_q || bus.flush) ? IDLE : HOLD;
            HOLD: state_d = bus.flush ? IDLE : !bus.wb_ready ? HOLD : issue ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // operand latch on issue, kill flag, result capture and illegal pulse
    always_comb begin
        op_alu_d = issue ? bus.in_is_op_alu : op_alu_q;
        op_imm_d = issue ? bus.in_is_op_alu_imm && !bus.in_is_op_alu : op_imm_q;
        funct3_d = issue ? bus.in_funct3 : funct3_q;
        funct7_d = issue ? bus.in_funct7 : funct7_q;
        rd_d = issue ? bus.in_rd : rd_q;
        rs1_d = issue ? bus.in_rs1_val : rs1_q;
        rs2_d = issue ? bus.in_rs2_val : rs2_q;
        imm_d = issue ? bus.in_imm : imm_q;
        killed_d = issue ? 1'b0 : killed_q || (exec && bus.flush);
        wb_data_d = done ? bus.rd_alu : wb_data_q;
        illegal_d = accept && bad_op;
    end
    // state and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_alu_q <= 1'b0;
            op_imm_q <= 1'b0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            killed_q <= 1'b0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_alu_q <= op_alu_d;
            op_imm_q <= op_imm_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            rd_q <= rd_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            imm_q <= imm_d;
            killed_q <= killed_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
        end
    end
    assign busy = (exec || hold) && rd_q != '0 && !killed_q && !bus.flush;
    // outputs: ALU side only live in EXEC so the ALU never sees a stray operation
    always_comb begin
        bus.in_ready = reset_n && (state_q == IDLE || (hold && bus.wb_ready));
        bus.is_op_alu = exec && op_alu_q;
        bus.is_op_alu_imm = exec && op_imm_q;
        bus.op_funct3 = exec ? funct3_q : '0;
        bus.op_funct7 = exec ? funct7_q : '0;
        bus.reg_s1 = exec ? rs1_q : '0;
        bus.reg_s2 = exec ? rs2_q : '0;
        bus.imm = exec ? imm_q : '0;
        bus.wb_valid = hold && !bus.flush;
        bus.wb_rd = hold ? rd_q : '0;
        bus.wb_data = hold ? wb_data_q : '0;
        bus.busy_valid = busy;
        bus.busy_rd = busy ? rd_q : '0;
        bus.illegal = illegal_q;
    end
    riscv_alu_issue_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_wd (
        .clock(clock),
        .reset_n(reset_n),
        .clear_i(issue),
        .run_i(exec),
        .err_o(bus.wd_err)
    );
endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb_riscv_alu_issue: directed vectors for the ALU issue stage with WAIT_LIMIT=8
module tb_riscv_alu_issue;
    import riscv_core_pkg::*;
`ifdef RISCV_M_EXT_EN
    localparam logic [6:0] F7_LONG = 7'h01;
`else
    localparam logic [6:0] F7_LONG = 7'h00;
`endif
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int n_cmp, n_bad;
    riscv_alu_issue_if bus();
    riscv_alu_issue #(.WAIT_LIMIT(8)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #2;
    endtask
    task automatic clear_inputs();
        bus.in_valid = 0; bus.in_is_op_alu = 0; bus.in_is_op_alu_imm = 0;
        bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_rd = 0;
        bus.in_rs1_val = 0; bus.in_rs2_val = 0; bus.in_imm = 0;
        bus.rd_alu = 0; bus.is_alu_wait = 0; bus.wb_ready = 0; bus.flush = 0;
    endtask
    task automatic drive(input logic alu, input logic im, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv);
        bus.in_valid = 1; bus.in_is_op_alu = alu; bus.in_is_op_alu_imm = im;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_rd = rd;
        bus.in_rs1_val = a; bus.in_rs2_val = b; bus.in_imm = iv;
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_inputs();
        #1 reset_n = 0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_wd_err", 32'(bus.wd_err), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        #10 reset_n = 1;
        tick();
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_busy", 32'(bus.busy_valid), 0);
        // ADD 5+7 -> rd3, result in N+2
        drive(1, 0, F3_ADD, 7'h00, 5'd3, 5, 7, 0);
        #1 chk("add_acc_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 0; bus.rd_alu = 12;
        #1;
        chk("add_exec_alu", 32'(bus.is_op_alu), 1);
        chk("add_exec_s1", bus.reg_s1, 5);
        chk("add_exec_s2", bus.reg_s2, 7);
        chk("add_exec_busy_rd", 32'(bus.busy_rd), 3);
        chk("add_exec_wb_valid", 32'(bus.wb_valid), 0);
        chk("add_exec_ready", 32'(bus.in_ready), 0);
        tick();
        bus.rd_alu = 32'hdead_beef;
        #1;
        chk("add_wb_valid", 32'(bus.wb_valid), 1);
        chk("add_wb_rd", 32'(bus.wb_rd), 3);
        chk("add_wb_data", bus.wb_data, 12);
        chk("add_hold_alu", 32'(bus.is_op_alu), 0);
        chk("add_hold_s1", bus.reg_s1, 0);
        chk("add_hold_ready", 32'(bus.in_ready), 0);
        chk("add_wd_err", 32'(bus.wd_err), 0);
        bus.wb_ready = 1;
        #1 chk("add_hold_ready_wb", 32'(bus.in_ready), 1);
        tick();
        bus.wb_ready = 0;
        #1;
        chk("add_done_wb_valid", 32'(bus.wb_valid), 0);
        chk("add_done_busy", 32'(bus.busy_valid), 0);
        // rd=0 retires without writeback
        drive(1, 0, F3_ADD, 7'h00, 5'd0, 1, 1, 0);
        tick();
        bus.in_valid = 0; bus.rd_alu = 2;
        #1 chk("rd0_busy", 32'(bus.busy_valid), 0);
        tick();
        #1;
        chk("rd0_wb_valid", 32'(bus.wb_valid), 0);
        chk("rd0_ready", 32'(bus.in_ready), 1);
        // immediate-only class
        drive(0, 1, F3_ADD, 7'h00, 5'd6, 10, 0, 32'hffff_fffc);
        tick();
        bus.in_valid = 0; bus.rd_alu = 6;
        #1;
        chk("imm_alu", 32'(bus.is_op_alu), 0);
        chk("imm_alu_imm", 32'(bus.is_op_alu_imm), 1);
        chk("imm_val", bus.imm, 32'hffff_fffc);
        tick();
        bus.wb_ready = 1;
        #1 chk("imm_wb_data", bus.wb_data, 6);
        tick();
        bus.wb_ready = 0;
        // both class bits -> register ALU
        drive(1, 1, F3_OR, 7'h00, 5'd8, 3, 4, 0);
        tick();
        bus.in_valid = 0; bus.rd_alu = 7;
        #1;
        chk("both_alu", 32'(bus.is_op_alu), 1);
        chk("both_alu_imm", 32'(bus.is_op_alu_imm), 0);
        chk("both_f3", 32'(bus.op_funct3), 32'(F3_OR));
        tick();
        bus.wb_ready = 1;
        #1 chk("both_wb_rd", 32'(bus.wb_rd), 8);
        tick();
        bus.wb_ready = 0;
        // DIV 100/7 with 9 stall cycles; watchdog trips after the 8th EXEC cycle
        drive(1, 0, F3_DIV, F7_LONG, 5'd3, 100, 7, 0);
        tick();
        bus.in_valid = 0; bus.is_alu_wait = 1; bus.rd_alu = 32'h1234;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("div_s1", bus.reg_s1, 100);
            chk("div_s2", bus.reg_s2, 7);
            chk("div_f3", 32'(bus.op_funct3), 32'(F3_DIV));
            chk("div_f7", 32'(bus.op_funct7), 32'(F7_LONG));
            chk("div_busy_rd", 32'(bus.busy_rd), 3);
            chk("div_wb_valid", 32'(bus.wb_valid), 0);
            chk("div_wd_err", 32'(bus.wd_err), (i >= 8) ? 1 : 0);
            tick();
        end
        bus.is_alu_wait = 0; bus.rd_alu = 14;
        #1 chk("div_last_s1", bus.reg_s1, 100);
        tick();
        bus.rd_alu = 32'hbad0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("div_hold_valid", 32'(bus.wb_valid), 1);
            chk("div_hold_data", bus.wb_data, 14);
            chk("div_hold_busy_rd", 32'(bus.busy_rd), 3);
            tick();
        end
        bus.wb_ready = 1;
        tick();
        bus.wb_ready = 0;
        #1;
        chk("div_done_valid", 32'(bus.wb_valid), 0);
        chk("div_done_busy", 32'(bus.busy_valid), 0);
        chk("div_wd_sticky", 32'(bus.wd_err), 1);
        reset_n = 0;
        #1 chk("wd_cleared_by_rst", 32'(bus.wd_err), 0);
        #1 reset_n = 1;
        tick();
        // MUL flushed on its 3rd EXEC cycle
        drive(1, 0, F3_MUL, F7_LONG, 5'd5, 6, 9, 0);
        tick();
        bus.in_valid = 0; bus.is_alu_wait = 1;
        #1 chk("mul_busy", 32'(bus.busy_valid), 1);
        tick();
        tick();
        bus.flush = 1;
        #1;
        chk("mul_flush_busy", 32'(bus.busy_valid), 0);
        chk("mul_flush_s1", bus.reg_s1, 6);
        tick();
        bus.flush = 0;
        #1;
        chk("mul_kill_s1", bus.reg_s1, 6);
        chk("mul_kill_s2", bus.reg_s2, 9);
        chk("mul_kill_alu", 32'(bus.is_op_alu), 1);
        chk("mul_kill_busy", 32'(bus.busy_valid), 0);
        tick();
        bus.is_alu_wait = 0; bus.rd_alu = 54;
        #1 chk("mul_end_s1", bus.reg_s1, 6);
        tick();
        #1;
        chk("mul_no_wb", 32'(bus.wb_valid), 0);
        chk("mul_ready", 32'(bus.in_ready), 1);
        chk("mul_alu_off", 32'(bus.is_op_alu), 0);
        tick();
        #1 chk("mul_no_wb2", 32'(bus.wb_valid), 0);
        // writeback back-pressure, then back-to-back issue in the handshake cycle
        drive(1, 0, F3_ADD, 7'h00, 5'd4, 1, 2, 0);
        tick();
        bus.in_valid = 0; bus.rd_alu = 3;
        tick();
        bus.rd_alu = 32'hffff;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", 32'(bus.wb_valid), 1);
            chk("bp_data", bus.wb_data, 3);
            chk("bp_rd", 32'(bus.wb_rd), 4);
            chk("bp_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.wb_ready = 1;
        drive(1, 0, F3_XOR, 7'h00, 5'd7, 32'hf0, 32'h0f, 0);
        #1;
        chk("bp_hs_ready", 32'(bus.in_ready), 1);
        chk("bp_hs_data", bus.wb_data, 3);
        tick();
        bus.in_valid = 0; bus.wb_ready = 0; bus.rd_alu = 32'hff;
        #1;
        chk("b2b_alu", 32'(bus.is_op_alu), 1);
        chk("b2b_f3", 32'(bus.op_funct3), 32'(F3_XOR));
        chk("b2b_s1", bus.reg_s1, 32'hf0);
        chk("b2b_wb_valid", 32'(bus.wb_valid), 0);
        tick();
        #1;
        chk("b2b_wb_data", bus.wb_data, 32'hff);
        chk("b2b_wb_rd", 32'(bus.wb_rd), 7);
        bus.wb_ready = 1;
        tick();
        bus.wb_ready = 0;
        // M-extension instruction
        drive(1, 0, F3_MUL, 7'h01, 5'd9, 3, 4, 0);
        #1 chk("m_acc_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 0; bus.rd_alu = 12;
`ifdef RISCV_M_EXT_EN
        #1;
        chk("m_alu", 32'(bus.is_op_alu), 1);
        chk("m_f7", 32'(bus.op_funct7), 1);
        chk("m_illegal", 32'(bus.illegal), 0);
        tick();
        #1 chk("m_wb_data", bus.wb_data, 12);
        bus.wb_ready = 1;
        tick();
        bus.wb_ready = 0;
`else
        #1;
        chk("m_illegal", 32'(bus.illegal), 1);
        chk("m_alu", 32'(bus.is_op_alu), 0);
        chk("m_f7", 32'(bus.op_funct7), 0);
        chk("m_busy", 32'(bus.busy_valid), 0);
        chk("m_idle_ready", 32'(bus.in_ready), 1);
        tick();
        #1;
        chk("m_illegal_pulse", 32'(bus.illegal), 0);
        chk("m_no_wb", 32'(bus.wb_valid), 0);
        chk("m_alu_off", 32'(bus.is_op_alu), 0);
`endif
        // watchdog with 10 stall cycles, then reset mid-EXEC
        drive(1, 0, F3_ADD, 7'h00, 5'd2, 11, 22, 0);
        tick();
        bus.in_valid = 0; bus.is_alu_wait = 1;
        for (int i = 0; i < 10; i++) begin
            #1 chk("wd_err", 32'(bus.wd_err), (i >= 8) ? 1 : 0);
            tick();
        end
        reset_n = 0;
        #1;
        chk("mid_rst_alu", 32'(bus.is_op_alu), 0);
        chk("mid_rst_s1", bus.reg_s1, 0);
        chk("mid_rst_busy", 32'(bus.busy_valid), 0);
        chk("mid_rst_wd", 32'(bus.wd_err), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 0);
        #1 reset_n = 1;
        bus.is_alu_wait = 0; bus.rd_alu = 99;
        #1 chk("post_rst_ready", 32'(bus.in_ready), 1);
        tick();
        #1 chk("post_rst_no_wb", 32'(bus.wb_valid), 0);
        tick();
        #1 chk("post_rst_no_wb2", 32'(bus.wb_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
